combo_sender: RTL and testbench

//  Initiator side of the safe's entry interface: replays a stored 3-part combination into the lock.
//  - Drives the lock's 6-bit entry switches and active-low action button.
//  - Watches the lock's status LEDs (LEDG) and advances only when the lock confirms each part.
//  - Sits between the test/auto-dial controller and the lock; replaces the human at SW[5:0]/action_n.

---
 rtl/lock_pkg.sv | 34 +++
 rtl/combo_hold_timer.sv | 29 ++
 rtl/combo_sender.sv | 192 +++++++++++++++++++
 tb/tb_combo_sender.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared encodings for the safe's entry interface: lock LEDG status codes,
// the combo_sender FSM states and the error codes it reports.
package lock_pkg;

    localparam logic [3:0] LOCK_SETUP = 4'b0000;
    localparam logic [3:0] LOCK_P0    = 4'b0001;
    localparam logic [3:0] LOCK_P1    = 4'b0011;
    localparam logic [3:0] LOCK_P2    = 4'b0111;
    localparam logic [3:0] LOCK_OPEN  = 4'b1111;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_START = 2'b01;
    localparam logic [1:0] ERR_NO_RESP   = 2'b10;
    localparam logic [1:0] ERR_RETRIES   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PRESS,
        ST_WAIT,
        ST_DONE,
        ST_FAIL
    } sender_state_e;

    // Lock status that confirms code part idx was accepted.
    function automatic logic [3:0] expected_lock(input logic [1:0] idx);
        case (idx)
            2'd0:    return LOCK_P1;
            2'd1:    return LOCK_P2;
            default: return LOCK_OPEN;
        endcase
    endfunction

endpackage

// File: rtl/combo_hold_timer.sv
// Down-counting hold timer: load with N, then expire_o rises on the N-th enabled
// cycle after the load. Shared by the SETUP, PRESS and WAIT phases of combo_sender.
module combo_hold_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - W'(1);
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/combo_sender.sv
// Replays a stored 3-part combination into the lock, advancing on LEDG confirmation.
// Optional COMBO_SENDER_ABORT_EN adds an abort input that forces FAIL (err 10).
module combo_sender
    import lock_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int WAIT_MAX  = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] code0,
    input  logic [5:0] code1,
    input  logic [5:0] code2,
    input  logic [3:0] lock_state,
`ifdef COMBO_SENDER_ABORT_EN
    input  logic       abort,
`endif
    output logic [5:0] sw_out,
    output logic       action_n_out,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] err_code,
    output logic [3:0] retries
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > WAIT_MAX) ? MAX_SP : WAIT_MAX;
    localparam int TW      = $clog2(MAX_CYC + 1);

    sender_state_e state_q;
    logic [1:0]    idx_q;
    logic [5:0]    code_q [3];
    logic [5:0]    sw_q;
    logic          act_n_q;
    logic          busy_q;
    logic          done_q;
    logic          fail_q;
    logic [1:0]    err_q;
    logic [3:0]    retries_q;

    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_expire;
    logic [TW-1:0] tmr_val;

    logic lock_hit, lock_relock, lock_clear, wait_event, accept, abort_req;

    assign lock_hit    = (lock_state == expected_lock(idx_q));
    assign lock_relock = (lock_state == LOCK_P0) && (idx_q != 2'd0);
    assign lock_clear  = (lock_state == LOCK_SETUP);
    assign wait_event  = (state_q == ST_WAIT) && (lock_hit || lock_relock || lock_clear);
    assign accept      = (state_q == ST_IDLE) && start && (lock_state == LOCK_P0);
    assign tmr_en      = (state_q == ST_SETUP) || (state_q == ST_PRESS) || (state_q == ST_WAIT);

`ifdef COMBO_SENDER_ABORT_EN
    assign abort_req = abort && tmr_en;
`else
    assign abort_req = 1'b0;
`endif

    // Every timed phase ends in a reload, so the load value is the next phase's length.
    assign tmr_load = accept || tmr_expire || wait_event;

    // NOTE: assign a default before the case so the combinational block never infers a latch.
    always_comb begin
        tmr_val = TW'(SETUP_CYC);
        case (state_q)
            ST_SETUP: tmr_val = TW'(PULSE_CYC);
            ST_PRESS: tmr_val = TW'(WAIT_MAX);
            default:  tmr_val = TW'(SETUP_CYC);
        endcase
    end

    combo_hold_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            // NOTE: the code registers are a handful of flops, so they are reset like all other state.
            code_q[0] <= '0;
            code_q[1] <= '0;
            code_q[2] <= '0;
            sw_q      <= '0;
            act_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= ERR_NONE;
            retries_q <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            if (abort_req) begin
                act_n_q <= 1'b1;
                busy_q  <= 1'b0;
                fail_q  <= 1'b1;
                err_q   <= ERR_NO_RESP;
                state_q <= ST_FAIL;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            code_q[0] <= code0;
                            code_q[1] <= code1;
                            code_q[2] <= code2;
                            idx_q     <= 2'd0;
                            retries_q <= '0;
                            err_q     <= ERR_NONE;
                            busy_q    <= 1'b1;
                            sw_q      <= code0;
                            act_n_q   <= 1'b1;
                            state_q   <= ST_SETUP;
                        end else if (start && lock_state == LOCK_OPEN) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (start) begin
                            fail_q  <= 1'b1;
                            err_q   <= ERR_BAD_START;
                            state_q <= ST_FAIL;
                        end
                    end
                    ST_SETUP: begin
                        if (tmr_expire) begin
                            act_n_q <= 1'b0;
                            state_q <= ST_PRESS;
                        end
                    end
                    ST_PRESS: begin
                        if (tmr_expire) begin
                            act_n_q <= 1'b1;
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (lock_hit) begin
                            if (idx_q == 2'd2) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                idx_q   <= idx_q + 2'd1;
                                sw_q    <= code_q[idx_q + 2'd1];
                                state_q <= ST_SETUP;
                            end
                        end else if (lock_relock) begin
                            // The lock's own timer relocked it: replay from part 0 if budget remains.
                            if (retries_q == 4'(RETRY_MAX)) begin
                                busy_q  <= 1'b0;
                                fail_q  <= 1'b1;
                                err_q   <= ERR_RETRIES;
                                state_q <= ST_FAIL;
                            end else begin
                                retries_q <= retries_q + 4'd1;
                                idx_q     <= 2'd0;
                                sw_q      <= code_q[0];
                                state_q   <= ST_SETUP;
                            end
                        end else if (lock_clear || tmr_expire) begin
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                            err_q   <= lock_clear ? ERR_BAD_START : ERR_NO_RESP;
                            state_q <= ST_FAIL;
                        end
                    end
                    ST_DONE, ST_FAIL: state_q <= ST_IDLE;
                    default:          state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sw_out       = sw_q;
    assign action_n_out = act_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign err_code     = err_q;
    assign retries      = retries_q;

endmodule

// File: tb/tb_combo_sender.sv
// Bench for combo_sender: behavioural lock model with 3-cycle press-to-LEDG latency
// and an outcome predictor derived from the combination/relock rules.
module tb_combo_sender;
    import lock_pkg::*;

    localparam int SETUP_CYC = 4;
    localparam int PULSE_CYC = 4;
    localparam int WAIT_MAX  = 16;
    localparam int RETRY_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] code0, code1, code2;
    logic [3:0] lock_state;
    logic [5:0] sw_out;
    logic       action_n_out, busy, done, fail;
    logic [1:0] err_code;
    logic [3:0] retries;
`ifdef COMBO_SENDER_ABORT_EN
    logic       abort = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [5:0] snd_code [3];
    assign code0 = snd_code[0];
    assign code1 = snd_code[1];
    assign code2 = snd_code[2];

    combo_sender #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .WAIT_MAX  (WAIT_MAX),
        .RETRY_MAX (RETRY_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .code0        (code0),
        .code1        (code1),
        .code2        (code2),
        .lock_state   (lock_state),
`ifdef COMBO_SENDER_ABORT_EN
        .abort        (abort),
`endif
        .sw_out       (sw_out),
        .action_n_out (action_n_out),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .err_code     (err_code),
        .retries      (retries)
    );

    // ---------------- behavioural lock model ----------------
    logic [5:0] m_code [3];
    int         m_budget;          // how many correct part-1 presses get relocked
    bit         m_force_en = 1'b1;
    logic [3:0] m_force_val = LOCK_P0;
    logic [3:0] lock_q;
    int         used, pend_cnt, low_cnt;
    logic [5:0] pend_sw;
    logic       act_prev;
    logic [5:0] press_log [256];
    int         width_log [256];
    int         press_cnt = 0;
    int         width_cnt = 0;

    assign lock_state = m_force_en ? m_force_val : lock_q;

    always @(negedge clk) begin
        if (m_force_en) begin
            lock_q   <= m_force_val;
            used     <= 0;
            pend_cnt <= 0;
            act_prev <= 1'b1;
            low_cnt  <= 0;
        end else begin
            act_prev <= action_n_out;
            if (act_prev && !action_n_out) begin
                press_log[press_cnt] <= sw_out;
                press_cnt <= press_cnt + 1;
                pend_sw   <= sw_out;
                pend_cnt  <= 3;
            end else if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    if (lock_q == LOCK_P0 && pend_sw == m_code[0]) lock_q <= LOCK_P1;
                    else if (lock_q == LOCK_P1 && pend_sw == m_code[1]) begin
                        if (used < m_budget) begin
                            lock_q <= LOCK_P0;
                            used   <= used + 1;
                        end else lock_q <= LOCK_P2;
                    end else if (lock_q == LOCK_P2 && pend_sw == m_code[2]) lock_q <= LOCK_OPEN;
                end
            end
            if (!action_n_out) low_cnt <= act_prev ? 1 : low_cnt + 1;
            else if (!act_prev) begin
                width_log[width_cnt] <= low_cnt;
                width_cnt <= width_cnt + 1;
            end
        end
    end

    // ---------------- outcome predictor ----------------
    bit         exp_done;
    logic [1:0] exp_err;
    int         exp_ret, exp_n;
    logic [5:0] exp_pr [32];

    function automatic void predict();
        int used_p = 0;
        int ret = 0;
        bit fin = 1'b0;
        exp_n = 0;
        exp_done = 1'b0;
        exp_err = ERR_NONE;
        while (!fin) begin
            for (int p = 0; p < 3; p++) begin
                exp_pr[exp_n] = snd_code[p];
                exp_n++;
                if (snd_code[p] != m_code[p]) begin
                    exp_err = ERR_NO_RESP;
                    fin = 1'b1;
                    break;
                end
                if (p == 1 && used_p < m_budget) begin
                    used_p++;
                    if (ret == RETRY_MAX) begin
                        exp_err = ERR_RETRIES;
                        fin = 1'b1;
                    end else ret++;
                    break;
                end
                if (p == 2) begin
                    exp_done = 1'b1;
                    fin = 1'b1;
                end
            end
        end
        exp_ret = ret;
    endfunction

    // ---------------- helpers ----------------
    int n_checks = 0;
    int n_fail = 0;
    bit got_done, got_fail, busy_seen, press_seen;
    int cyc, p_base, w_base;

    task automatic init_model(input logic [3:0] st, input bit keep_forced);
        @(negedge clk);
        m_force_val = st;
        m_force_en  = 1'b1;
        repeat (2) @(negedge clk);
        m_force_en = keep_forced;
    endtask

    task automatic do_run(input int budget);
        p_base = press_cnt;
        w_base = width_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_seen = busy;
        press_seen = !action_n_out;
        while (!done && !fail && cyc < budget) begin
            @(negedge clk);
            cyc++;
            busy_seen |= busy;
            press_seen |= !action_n_out;
        end
        got_done = done;
        got_fail = fail;
        @(negedge clk);   // let the model log the final release
    endtask

    task automatic set_codes(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        m_code[0] = a; m_code[1] = b; m_code[2] = c;
        snd_code[0] = a; snd_code[1] = b; snd_code[2] = c;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        if ({sw_out, action_n_out, busy, done, fail, err_code, retries} !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0}) begin
            $display("FAIL reset_values: got sw=%0d act_n=%b busy=%b done=%b fail=%b err=%b ret=%0d required sw=0 act_n=1 busy=0 done=0 fail=0 err=00 ret=0",
                     sw_out, action_n_out, busy, done, fail, err_code, retries);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compares one finished run against the predictor.
    task automatic test_sequence(input string name, input int max_cyc);
        predict();
        do_run(300);
        if (got_done !== exp_done || got_fail !== !exp_done) begin
            $display("FAIL %s outcome: got done=%b fail=%b required done=%b fail=%b (cycles %0d)", name, got_done, got_fail, exp_done, !exp_done, cyc);
            n_fail++;
        end
        n_checks++;
        if (err_code !== exp_err || retries !== 4'(exp_ret)) begin
            $display("FAIL %s err/retries: got %b/%0d required %b/%0d", name, err_code, retries, exp_err, exp_ret);
            n_fail++;
        end
        n_checks++;
        if (press_cnt - p_base != exp_n) begin
            $display("FAIL %s press_count: got %0d required %0d", name, press_cnt - p_base, exp_n);
            n_fail++;
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                if (press_log[p_base + i] !== exp_pr[i] || width_log[w_base + i] != PULSE_CYC) begin
                    $display("FAIL %s press[%0d]: got code %0d width %0d required code %0d width %0d",
                             name, i, press_log[p_base + i], width_log[w_base + i], exp_pr[i], PULSE_CYC);
                    n_fail++;
                end
                n_checks++;
            end
        end
        n_checks++;
        if (action_n_out !== 1'b1 || busy !== 1'b0 || cyc > max_cyc) begin
            $display("FAIL %s idle_after: got act_n=%b busy=%b cycles=%0d required act_n=1 busy=0 cycles<=%0d",
                     name, action_n_out, busy, cyc, max_cyc);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_basic();
        set_codes(6'd12, 6'd34, 6'd56);
        m_budget = 0;
        init_model(LOCK_P0, 1'b0);
        test_sequence("basic", 3 * (SETUP_CYC + PULSE_CYC + 4));
    endtask

    task automatic test_wrong_code();
        set_codes(6'd12, 6'd34, 6'd56);
        snd_code[1] = 6'd35;
        m_budget = 0;
        init_model(LOCK_P0, 1'b0);
        test_sequence("wrong_code", 40);
        if (cyc < 2 * (SETUP_CYC + PULSE_CYC) + WAIT_MAX) begin
            $display("FAIL wrong_code timeout_len: got %0d cycles required >= %0d", cyc, 2 * (SETUP_CYC + PULSE_CYC) + WAIT_MAX);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_relock_once();
        set_codes(6'd12, 6'd34, 6'd56);
        m_budget = 1;
        init_model(LOCK_P0, 1'b0);
        test_sequence("relock_once", 300);
    endtask

    task automatic test_relock_always();
        set_codes(6'd12, 6'd34, 6'd56);
        m_budget = 99;
        init_model(LOCK_P0, 1'b0);
        test_sequence("relock_always", 300);
    endtask

    task automatic test_start_states();
        set_codes(6'd1, 6'd2, 6'd3);
        init_model(LOCK_SETUP, 1'b1);
        do_run(10);
        if (!got_fail || got_done || err_code !== ERR_BAD_START || busy_seen || press_seen) begin
            $display("FAIL start_0000: got fail=%b done=%b err=%b busy_seen=%b press_seen=%b required fail=1 done=0 err=01 busy_seen=0 press_seen=0",
                     got_fail, got_done, err_code, busy_seen, press_seen);
            n_fail++;
        end
        n_checks++;
        init_model(LOCK_OPEN, 1'b1);
        do_run(10);
        if (!got_done || got_fail || cyc != 1 || busy_seen || press_seen) begin
            $display("FAIL start_1111: got done=%b fail=%b cycles=%0d busy_seen=%b press_seen=%b required done=1 fail=0 cycles=1 busy_seen=0 press_seen=0",
                     got_done, got_fail, cyc, busy_seen, press_seen);
            n_fail++;
        end
        n_checks++;
        m_force_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int base;
        set_codes(6'd7, 6'd63, 6'd0);
        m_budget = 0;
        init_model(LOCK_P0, 1'b0);
        base = press_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;          // ignored: sender is busy
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        if (dones != 1 || press_cnt - base != 3 || busy !== 1'b0) begin
            $display("FAIL busy_start: got dones=%0d presses=%0d busy=%b required dones=1 presses=3 busy=0", dones, press_cnt - base, busy);
            n_fail++;
        end
        n_checks++;
        init_model(LOCK_P0, 1'b0);
        test_sequence("back_to_back", 3 * (SETUP_CYC + PULSE_CYC + 4));
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int r;
            for (int p = 0; p < 3; p++) begin
                m_code[p]   = 6'($urandom_range(0, 63));
                snd_code[p] = m_code[p];
            end
            r = $urandom_range(0, 5);
            if (r < 3) snd_code[r] = m_code[r] ^ 6'($urandom_range(1, 63));
            m_budget = $urandom_range(0, 5);
            init_model(LOCK_P0, 1'b0);
            test_sequence($sformatf("random%0d", it), 300);
        end
    endtask

    task automatic test_reset_mid_press();
        int k = 0;
        set_codes(6'd21, 6'd42, 6'd9);
        m_budget = 0;
        init_model(LOCK_P0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (action_n_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (action_n_out !== 1'b0) begin
            $display("FAIL reset_mid_press press_reached: got act_n=%b required 0", action_n_out);
            n_fail++;
        end
        n_checks++;
        #2 rst_n = 1'b0;
        #1;
        if (action_n_out !== 1'b1 || busy !== 1'b0 || sw_out !== 6'd0) begin
            $display("FAIL reset_mid_press: got act_n=%b busy=%b sw=%0d required act_n=1 busy=0 sw=0", action_n_out, busy, sw_out);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort();
`ifdef COMBO_SENDER_ABORT_EN
        int k = 0;
        set_codes(6'd5, 6'd6, 6'd7);
        snd_code[0] = 6'd4;    // lock never advances, so the sender sits in WAIT
        m_budget = 0;
        init_model(LOCK_P0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (action_n_out && k < 20) begin @(negedge clk); k++; end
        while (!action_n_out && k < 40) begin @(negedge clk); k++; end
        abort = 1'b1;
        @(negedge clk);
        if (fail !== 1'b1 || err_code !== ERR_NO_RESP || action_n_out !== 1'b1) begin
            $display("FAIL abort_wait: got fail=%b err=%b act_n=%b required fail=1 err=10 act_n=1", fail, err_code, action_n_out);
            n_fail++;
        end
        n_checks++;
        abort = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || fail !== 1'b0) begin
            $display("FAIL abort_after: got busy=%b fail=%b required busy=0 fail=0", busy, fail);
            n_fail++;
        end
        n_checks++;
`endif
    endtask

    initial begin
        snd_code[0] = '0; snd_code[1] = '0; snd_code[2] = '0;
        m_code[0] = '0; m_code[1] = '0; m_code[2] = '0;
        m_budget = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_wrong_code();
        test_relock_once();
        test_relock_always();
        test_start_states();
        test_back_to_back();
        test_random();
        test_reset_mid_press();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
